loadable_counter: RTL and testbench



---
 rtl/loadable_counter_if.sv | 46 ++++
 rtl/loadable_counter.sv | 79 +++++++
 tb/tb_loadable_counter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/loadable_counter_if.sv
// loadable_counter_if
//   Groups the load/direction controls and the count outputs of
//   loadable_counter into one bundle.
//
//   Parameters:
//     WIDTH   counter width in bits (legal >= 2)
//
//   Signals:
//     ld      synchronous load enable
//     d       parallel load value
//     updown  direction: 1 = up, 0 = down
//     q       registered counter value
//     tc      terminal count for the current direction
//     zero    q == 0
//
//   Modports:
//     master  drives ld/d/updown, observes q/tc/zero
//     slave   the counter side
interface loadable_counter_if #(
    parameter int WIDTH = 4
);
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             updown;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             zero;

    modport master (
        output ld,
        output d,
        output updown,
        input  q,
        input  tc,
        input  zero
    );

    modport slave (
        input  ld,
        input  d,
        input  updown,
        output q,
        output tc,
        output zero
    );
endinterface

// File: rtl/loadable_counter.sv
// loadable_counter
//   Up/down binary counter with synchronous parallel load and
//   asynchronous active-high reset. Steps once per clock in the
//   direction selected by updown; a load takes priority over counting.
//   Terminal-count and zero flags are decoded combinationally from q.
//
//   Build option:
//     LOADABLE_COUNTER_SAT_EN  when defined, counting saturates at
//                              all-ones (up) and zero (down) instead
//                              of wrapping; load and reset unchanged.
//
//   Parameters:
//     WIDTH   counter width in bits (legal >= 2)
//
//   Ports:
//     clk     rising-edge clock
//     rst     asynchronous reset, active-high, forces q to 0
//     bus     loadable_counter_if.slave: ld, d, updown in; q, tc, zero out
module loadable_counter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    loadable_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic             at_max;
    logic             at_min;

    assign at_max = (count == ALL_ONES);
    assign at_min = (count == ALL_ZERO);

    // Next value: load beats counting, so a load coinciding with a
    // wrap/saturation condition simply takes d.
    always_comb begin
        count_next = count;
        if (bus.ld) begin
            count_next = bus.d;
        end else if (bus.updown) begin
`ifdef LOADABLE_COUNTER_SAT_EN
            if (!at_max) begin
                count_next = count + 1'b1;
            end
`else
            count_next = count + 1'b1;
`endif
        end else begin
`ifdef LOADABLE_COUNTER_SAT_EN
            if (!at_min) begin
                count_next = count - 1'b1;
            end
`else
            count_next = count - 1'b1;
`endif
        end
    end

    // Reset is the only term in the sensitivity besides clk, so ld/d/updown
    // cannot reach the register while rst is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign bus.q    = count;
    assign bus.zero = at_min;
    // Limit in the current direction; in the saturating build this is
    // exactly the "pinned" condition as well.
    assign bus.tc   = bus.updown ? at_max : at_min;

endmodule

// File: tb/tb_loadable_counter.sv
module tb_loadable_counter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    loadable_counter_if #(.WIDTH(W)) bus ();

    loadable_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         ld;
        logic [W-1:0] d;
        logic         updown;
        logic [W-1:0] q;
        logic         tc;
        logic         zero;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;

    function automatic void add(input logic r, input logic l, input int dv,
                                input logic u, input int qv, input logic t,
                                input logic z);
        vec_t v;
        v.rst    = r;
        v.ld     = l;
        v.d      = dv[W-1:0];
        v.updown = u;
        v.q      = qv[W-1:0];
        v.tc     = t;
        v.zero   = z;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int idx,
                             input int qv, input logic t, input logic z);
        check({name, ".q"},    idx, 32'(bus.q),    32'(qv));
        check({name, ".tc"},   idx, 32'(bus.tc),   32'(t));
        check({name, ".zero"}, idx, 32'(bus.zero), 32'(z));
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic l, input int dv, input logic u);
        @(negedge clk);
        rst        = r;
        bus.ld     = l;
        bus.d      = dv[W-1:0];
        bus.updown = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with controls left undriven.
        rst        = 1'b1;
        bus.ld     = 'x;
        bus.d      = 'x;
        bus.updown = 'x;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x.q",    0, 32'(bus.q),    32'd0);
        check("rst_x.zero", 0, 32'(bus.zero), 32'd1);

        // Table: {rst, ld, d, updown} -> {q, tc, zero} after the edge.
        add(1, 1,  5, 1,  0, 0, 1);   // load ignored under reset
        add(1, 0,  0, 0,  0, 1, 1);   // tc follows updown=0 at q=0
        add(0, 0,  0, 1,  1, 0, 0);   // first edge after release counts
        add(0, 1,  9, 1,  9, 0, 0);
        add(0, 0,  0, 1, 10, 0, 0);
        add(0, 0,  0, 1, 11, 0, 0);
        add(0, 0,  0, 1, 12, 0, 0);
        add(0, 0,  0, 1, 13, 0, 0);
        add(0, 0,  0, 1, 14, 0, 0);
        add(0, 0,  0, 1, 15, 1, 0);
`ifdef LOADABLE_COUNTER_SAT_EN
        add(0, 0,  0, 1, 15, 1, 0);
        add(0, 0,  0, 1, 15, 1, 0);
`else
        add(0, 0,  0, 1,  0, 0, 1);
        add(0, 0,  0, 1,  1, 0, 0);
`endif
        add(0, 1,  2, 0,  2, 0, 0);
        add(0, 0,  0, 0,  1, 0, 0);
        add(0, 0,  0, 0,  0, 1, 1);
`ifdef LOADABLE_COUNTER_SAT_EN
        add(0, 0,  0, 0,  0, 1, 1);
        add(0, 0,  0, 0,  0, 1, 1);
`else
        add(0, 0,  0, 0, 15, 0, 0);
        add(0, 0,  0, 0, 14, 0, 0);
`endif
        add(0, 1,  5, 1,  5, 0, 0);
        add(0, 0,  0, 1,  6, 0, 0);
        add(0, 0,  0, 0,  5, 0, 0);   // direction change: no repeat/skip
        add(0, 0,  0, 0,  4, 0, 0);
        add(0, 1, 15, 1, 15, 1, 0);
        add(0, 1,  3, 1,  3, 0, 0);   // load wins over wrap at all-ones
        add(0, 1,  0, 0,  0, 1, 1);
        add(0, 1,  7, 0,  7, 0, 0);   // load wins over wrap at zero

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ld, 32'(vecs[i].d), vecs[i].updown);
            check_all("vec", i, 32'(vecs[i].q), vecs[i].tc, vecs[i].zero);
        end

        // Asynchronous reset between edges, load under reset discarded.
        step(0, 1, 11, 1);
        check("ar.q_pre", 0, 32'(bus.q), 32'd11);
        @(negedge clk);
        #2;
        rst    = 1'b1;
        bus.ld = 1'b1;
        bus.d  = 4'd9;
        #1;
        check("ar.q_async",    0, 32'(bus.q),    32'd0);
        check("ar.zero_async", 0, 32'(bus.zero), 32'd1);
        @(posedge clk);
        #1;
        check("ar.q_held", 0, 32'(bus.q), 32'd0);
        step(0, 0, 0, 1);
        check("ar.q_release", 0, 32'(bus.q), 32'd1);

        // tc tracks updown combinationally with q held at 0.
        step(0, 1, 0, 1);
        check_all("tcmux", 0, 0, 0, 1);
        @(negedge clk);
        bus.updown = 1'b0;
        #1;
        check("tcmux.tc_down", 1, 32'(bus.tc), 32'd1);
        bus.updown = 1'b1;
        #1;
        check("tcmux.tc_up", 2, 32'(bus.tc), 32'd0);

`ifdef LOADABLE_COUNTER_SAT_EN
        step(0, 1, 14, 1); check_all("sat_up", 0, 14, 0, 0);
        step(0, 0,  0, 1); check_all("sat_up", 1, 15, 1, 0);
        step(0, 0,  0, 1); check_all("sat_up", 2, 15, 1, 0);
        step(0, 0,  0, 1); check_all("sat_up", 3, 15, 1, 0);
        step(0, 1,  1, 0); check_all("sat_dn", 0,  1, 0, 0);
        step(0, 0,  0, 0); check_all("sat_dn", 1,  0, 1, 1);
        step(0, 0,  0, 0); check_all("sat_dn", 2,  0, 1, 1);
        step(0, 0,  0, 0); check_all("sat_dn", 3,  0, 1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
